core_axi_ram_slave: RTL and testbench

- AXI4 slave (responder) word-addressable RAM that serves the core's AXI master ports: the instruction fetch port and the data load/store port, one instance each.
- Synthesizable replacement for the behavioural slave BFMs, so core-level benches and the FPGA build run against real responder logic on the core clock.
- Independent read and write channels; INCR/FIXED bursts up to 256 beats; byte strobes.

---
 rtl/core_axi_ram_slave.sv | 182 ++++++++++++++++++
 tb/tb_core_axi_ram_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_axi_ram_slave.sv
// AXI4 responder backed by a word-addressed RAM; independent read and write FSMs,
// INCR/FIXED bursts up to 256 beats, byte strobes, SLVERR on unsupported size/burst.
module core_axi_ram_slave #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_OFFSET_WIDTH   = 28,
  parameter int unsigned C_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_MEM_WORDS_LOG2 = 12
) (
  input  logic                          CCLK,
  input  logic                          CRST,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_OFFSET_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int unsigned IW    = C_MEM_WORDS_LOG2;
  localparam int unsigned DEPTH = 2 ** C_MEM_WORDS_LOG2;
  localparam int unsigned NB    = C_AXI_DATA_WIDTH / 8;

  logic [C_AXI_DATA_WIDTH-1:0] ram_array [0:DEPTH-1];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e      w_state;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len, w_cnt;
  logic          w_fixed, w_err;

  r_state_e      r_state;
  logic [IW-1:0] r_idx, r_idx_nxt;
  logic [7:0]    r_len, r_cnt, r_cnt_nxt;
  logic          r_fixed, r_err;

  logic          aw_err, ar_err, w_last_beat, w_last_bad;
  logic [IW-1:0] aw_idx, ar_idx;

  // Upper address bits alias and byte-offset bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR[C_OFFSET_WIDTH-1:IW+2], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[C_OFFSET_WIDTH-1:IW+2], S_AXI_ARADDR[1:0]};

  assign aw_idx      = S_AXI_AWADDR[IW+1:2];
  assign ar_idx      = S_AXI_ARADDR[IW+1:2];
  assign aw_err      = (S_AXI_AWSIZE != 3'b010) || S_AXI_AWBURST[1];
  assign ar_err      = (S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1];
  assign w_last_beat = (w_cnt == w_len);
  assign w_last_bad  = (S_AXI_WLAST != w_last_beat);
  assign r_idx_nxt   = r_fixed ? r_idx : r_idx + 1'b1;
  assign r_cnt_nxt   = r_cnt + 8'd1;

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_BID     <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_fixed       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          S_AXI_BID     <= S_AXI_AWID;
          w_idx         <= aw_idx;
          w_len         <= S_AXI_AWLEN;
          w_cnt         <= '0;
          w_fixed       <= ~S_AXI_AWBURST[0];
          w_err         <= aw_err;
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (S_AXI_WVALID) begin
          w_cnt <= w_cnt + 8'd1;
          if (!w_fixed) w_idx <= w_idx + 1'b1;
          if (w_last_bad) w_err <= 1'b1;
          if (w_last_beat) begin
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= (w_err || w_last_bad) ? 2'b10 : 2'b00;
            w_state      <= W_RESP;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID  <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          w_state       <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Error state is sampled before this beat, so the beat that reveals a WLAST mismatch still lands.
  always_ff @(posedge CCLK) begin
    if (!CRST && w_state == W_DATA && S_AXI_WVALID && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) ram_array[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RRESP   <= 2'b00;
      S_AXI_RID     <= '0;
      S_AXI_RDATA   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_fixed       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          S_AXI_RID     <= S_AXI_ARID;
          r_idx         <= ar_idx;
          r_len         <= S_AXI_ARLEN;
          r_cnt         <= '0;
          r_fixed       <= ~S_AXI_ARBURST[0];
          r_err         <= ar_err;
          S_AXI_RDATA   <= ar_err ? '0 : ram_array[ar_idx];
          S_AXI_RRESP   <= ar_err ? 2'b10 : 2'b00;
          S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
          S_AXI_RVALID  <= 1'b1;
          S_AXI_ARREADY <= 1'b0;
          r_state       <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) begin
          if (S_AXI_RLAST) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end else begin
            r_idx       <= r_idx_nxt;
            r_cnt       <= r_cnt_nxt;
            S_AXI_RDATA <= r_err ? '0 : ram_array[r_idx_nxt];
            S_AXI_RLAST <= (r_cnt_nxt == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_axi_ram_slave.sv
// Scoreboard bench for core_axi_ram_slave: expected read beats are queued at stimulus time.
module tb_core_axi_ram_slave;

  logic        CCLK = 1'b0;
  logic        CRST = 1'b1;
  logic [0:0]  S_AXI_AWID = '0, S_AXI_ARID = '0, S_AXI_BID, S_AXI_RID;
  logic [27:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_AWSIZE = 3'b010, S_AXI_ARSIZE = 3'b010;
  logic [1:0]  S_AXI_AWBURST = 2'b01, S_AXI_ARBURST = 2'b01;
  logic        S_AXI_AWVALID = 1'b0, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY = 1'b0;
  logic        S_AXI_ARVALID = 1'b0, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];

  always #5 CCLK = ~CCLK;

  core_axi_ram_slave dut (
    .CCLK(CCLK), .CRST(CRST),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [1:0] resp);
    exp_q.push_back({resp, data});
  endtask

  // Full write transaction: AW, len+1 beats of data base+i, then B.
  task automatic wr_burst(input logic [27:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] strb,
                          input logic [31:0] base, input bit early, input logic [0:0] id,
                          input logic [1:0] exp_resp, input string name);
    int n;
    S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWSIZE = size;
    S_AXI_AWBURST = burst; S_AXI_AWID = id; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin tick(); n++; end
    tick();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_AXI_WDATA = base + 32'(i); S_AXI_WSTRB = strb;
      S_AXI_WLAST = early ? 1'b1 : (i == int'(len));
      S_AXI_WVALID = 1'b1;
      n = 0;
      while (!S_AXI_WREADY && n < 100) begin tick(); n++; end
      tests++;
      if (n >= 100) begin
        fails++; $display("FAIL %s w_ready_timeout beat=%0d got=0 want=1", name, i);
      end
      tick();
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 100) begin tick(); n++; end
    tests++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_resp || S_AXI_BID !== id) begin
      fails++;
      $display("FAIL %s bresp got=%b/%b/%b want=1/%b/%b", name, S_AXI_BVALID, S_AXI_BRESP,
               S_AXI_BID, exp_resp, id);
    end
    tick();
    S_AXI_BREADY = 1'b0;
    tests++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
      fails++; $display("FAIL %s idle_after_b got=%b/%b want=1/0", name, S_AXI_AWREADY,
                        S_AXI_BVALID);
    end
  endtask

  // Read transaction; expected beats must already be queued. toggle stalls every other cycle.
  task automatic rd_burst(input logic [27:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [0:0] id, input bit toggle,
                          input string name);
    int n, beats;
    logic [33:0] e;
    logic [31:0] held;
    bit held_v;
    S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARSIZE = size;
    S_AXI_ARBURST = burst; S_AXI_ARID = id; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 100) begin tick(); n++; end
    tick();
    S_AXI_ARVALID = 1'b0;
    tests++;
    if (S_AXI_RVALID !== 1'b1) begin
      fails++; $display("FAIL %s r_latency rvalid got=%b want=1", name, S_AXI_RVALID);
    end
    beats = 0; n = 0; held_v = 0; held = '0;
    while (beats <= int'(len) && n < 2000) begin
      S_AXI_RREADY = toggle ? ((n % 2) == 1) : 1'b1;
      if (S_AXI_RVALID) begin
        if (held_v) begin
          tests++;
          if (S_AXI_RDATA !== held) begin
            fails++; $display("FAIL %s stall_hold got=%h want=%h", name, S_AXI_RDATA, held);
          end
        end
        if (S_AXI_RREADY) begin
          held_v = 0;
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL %s scoreboard_empty got=%h want=none", name, S_AXI_RDATA);
          end else begin
            e = exp_q.pop_front();
            if (S_AXI_RDATA !== e[31:0] || S_AXI_RRESP !== e[33:32] ||
                S_AXI_RLAST !== (beats == int'(len)) || S_AXI_RID !== id) begin
              fails++;
              $display("FAIL %s beat%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", name, beats,
                       S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID, e[31:0], e[33:32],
                       (beats == int'(len)), id);
            end
          end
          beats++;
        end else begin
          held = S_AXI_RDATA; held_v = 1;
        end
      end
      tick();
      n++;
    end
    S_AXI_RREADY = 1'b0;
    tests++;
    if (beats != int'(len) + 1 || (!toggle && n != int'(len) + 1)) begin
      fails++; $display("FAIL %s r_throughput beats=%0d cycles=%0d want=%0d", name, beats, n,
                        int'(len) + 1);
    end
    tests++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      fails++; $display("FAIL %s r_idle got=%b/%b want=0/1", name, S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_reset();
    CRST = 1'b1;
    repeat (3) tick();
    CRST = 1'b0;
    tests++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1 || S_AXI_BVALID !== 1'b0 ||
        S_AXI_RVALID !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
      fails++;
      $display("FAIL reset aw/ar/b/r/w got=%b%b%b%b%b want=11000", S_AXI_AWREADY, S_AXI_ARREADY,
               S_AXI_BVALID, S_AXI_RVALID, S_AXI_WREADY);
    end
  endtask

  task automatic test_single_read();
    push_exp(32'h1234_5678, 2'b00);
    rd_burst(28'h4, 8'd0, 3'b010, 2'b01, 1'b1, 1'b0, "single_read");
  endtask

  task automatic test_incr_write_read();
    wr_burst(28'h10, 8'd3, 3'b010, 2'b01, 4'hF, 32'hA0, 1'b0, 1'b1, 2'b00, "incr_write");
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dut.ram_array[4+i] !== 32'hA0 + 32'(i)) begin
        fails++; $display("FAIL incr_mem[%0d] got=%h want=%h", 4 + i, dut.ram_array[4+i],
                          32'hA0 + 32'(i));
      end
      push_exp(32'hA0 + 32'(i), 2'b00);
    end
    rd_burst(28'h10, 8'd3, 3'b010, 2'b01, 1'b0, 1'b0, "incr_read");
  endtask

  task automatic test_strobe();
    wr_burst(28'h8, 8'd0, 3'b010, 2'b01, 4'b0010, 32'h0000_1200, 1'b0, 1'b0, 2'b00, "strobe");
    push_exp(32'hFFFF_12FF, 2'b00);
    rd_burst(28'h8, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0, "strobe_read");
  endtask

  task automatic test_errors();
    wr_burst(28'h20, 8'd1, 3'b010, 2'b10, 4'hF, 32'hDEAD_0000, 1'b0, 1'b1, 2'b10, "bad_burst");
    tests++;
    if (dut.ram_array[8] !== 32'h5555_5555 || dut.ram_array[9] !== 32'h6666_6666) begin
      fails++; $display("FAIL bad_burst_mem got=%h/%h want=55555555/66666666",
                        dut.ram_array[8], dut.ram_array[9]);
    end
    push_exp(32'h0, 2'b10);
    rd_burst(28'h20, 8'd0, 3'b001, 2'b01, 1'b1, 1'b0, "bad_size_read");
    wr_burst(28'h30, 8'd1, 3'b010, 2'b01, 4'hF, 32'h77, 1'b1, 1'b0, 2'b10, "early_wlast");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) push_exp(32'hC000_0000 + 32'(i * 3), 2'b00);
    rd_burst(28'h80, 8'd3, 3'b010, 2'b01, 1'b1, 1'b1, "stall_read");
  endtask

  task automatic test_fixed_read();
    for (int i = 0; i < 3; i++) push_exp(32'hC000_0003, 2'b00);
    rd_burst(28'h84, 8'd2, 3'b010, 2'b00, 1'b0, 1'b0, "fixed_read");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    S_AXI_AWADDR = 28'h40; S_AXI_AWLEN = 8'd3; S_AXI_AWSIZE = 3'b010;
    S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 100) begin tick(); n++; end
    tick();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      S_AXI_WDATA = 32'hB0 + 32'(i); S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      tick();
    end
    S_AXI_WDATA = 32'hB2; CRST = 1'b1;
    tick();
    CRST = 1'b0;
    tests++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
      fails++; $display("FAIL reset_mid_idle got=%b%b%b want=100", S_AXI_AWREADY, S_AXI_WREADY,
                        S_AXI_BVALID);
    end
    S_AXI_WDATA = 32'hB3;
    repeat (3) tick();
    S_AXI_WVALID = 1'b0;
    tests++;
    if (dut.ram_array[16] !== 32'hB0 || dut.ram_array[17] !== 32'hB1 ||
        dut.ram_array[18] !== 32'h0 || dut.ram_array[19] !== 32'h0) begin
      fails++; $display("FAIL reset_mid_mem got=%h/%h/%h/%h want=b0/b1/0/0", dut.ram_array[16],
                        dut.ram_array[17], dut.ram_array[18], dut.ram_array[19]);
    end
  endtask

  task automatic test_alias();
    wr_burst(28'h4000, 8'd0, 3'b010, 2'b01, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, "alias_wr");
    tests++;
    if (dut.ram_array[0] !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL alias_mem got=%h want=cafef00d", dut.ram_array[0]);
    end
    push_exp(32'hCAFE_F00D, 2'b00);
    rd_burst(28'h0, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0, "alias_rd");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dut.ram_array[i] = 32'h0;
    dut.ram_array[1] = 32'h1234_5678;
    dut.ram_array[2] = 32'hFFFF_FFFF;
    dut.ram_array[8] = 32'h5555_5555;
    dut.ram_array[9] = 32'h6666_6666;
    for (int i = 0; i < 4; i++) dut.ram_array[32+i] = 32'hC000_0000 + 32'(i * 3);
    test_reset();
    test_single_read();
    test_incr_write_read();
    test_strobe();
    test_errors();
    test_stall();
    test_fixed_read();
    test_reset_mid_burst();
    test_alias();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
